// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: shift mode encoding.
// Build option ROTATE_EN enables the rotate-left mode in shift_stage.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One combinational shift step of fixed distance DIST for the selected mode.
// With ROTATE_EN undefined, mode 11 falls through to SLL and no wrap path exists.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (en) begin
            case (shift_mode_t'(mode))
                SH_SRL:  result = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
                // sign is the original operand MSB, not this stage's MSB
                SH_SRA:  result = {{DIST{sign}}, data[WIDTH-1:DIST]};
`ifdef ROTATE_EN
                SH_ROL:  result = {data[WIDTH-1-DIST:0], data[WIDTH-1:WIDTH-DIST]};
`endif
                default: result = {data[WIDTH-1-DIST:0], {DIST{1'b0}}};
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, global stall.
// Define ROTATE_EN to make mode 11 a rotate-left; otherwise it behaves as SLL.
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amt;
        shift_mode_t      mode;
        logic             sign;
    } slot_t;

    logic  adv;
    slot_t head;

    assign head = '{valid: in_valid, data: in_data, amt: in_amt,
                    mode: shift_mode_t'(in_mode), sign: in_data[WIDTH-1]};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        slot_t            src;
        slot_t            q;
        logic [WIDTH-1:0] shifted;
        logic             unused_ctrl;

        if (k == 0) begin : g_head
            assign src = head;
        end else begin : g_link
            assign src = g_stage[k-1].q;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .data   (src.data),
            .en     (src.amt[k]),
            .mode   (src.mode),
            .sign   (src.sign),
            .result (shifted)
        );

        // bubbles advance with the rest; nothing is collapsed during a stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv) begin
                q <= '{valid: src.valid, data: shifted, amt: src.amt,
                       mode: src.mode, sign: src.sign};
            end
        end

        // control fields already consumed by this or earlier stages
        assign unused_ctrl = ^{q.amt, q.mode, q.sign};
    end

    assign out_valid = g_stage[SHW-1].q.valid;
    assign out_data  = g_stage[SHW-1].q.data;
    assign out_zero  = out_valid & ~|out_data;
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=8, latency 3).
// Honours ROTATE_EN for the mode-11 expectations.
module tb_pipelined_barrel_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;

    int errors = 0;
    int checks = 0;

    logic [7:0] got[$];
    bit         mon_en = 1'b0;

    pipelined_barrel_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // inputs only change #1 after posedge, so negedge sees the values the next edge uses
    always @(negedge clk)
        if (mon_en && out_valid && out_ready) got.push_back(out_data);

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input int m);
        logic [7:0] r;
        int         me;
        me = m;
`ifndef ROTATE_EN
        if (me == 3) me = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            case (me)
                0:       r[i] = (i >= a) ? d[i-a] : 1'b0;
                1:       r[i] = (i + a < 8) ? d[i+a] : 1'b0;
                2:       r[i] = (i + a < 8) ? d[i+a] : d[7];
                default: r[i] = d[(i - a + 8) % 8];
            endcase
        end
        return r;
    endfunction

    task automatic flush();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; in_mode = 2'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
        if (out_valid !== 1'b0) errors++;
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h want=00", out_data); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got=%b want=0", out_zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        int nm;
`ifdef ROTATE_EN
        nm = 4;
`else
        nm = 3;
`endif
        out_ready = 1'b1;
        for (int m = 0; m < nm; m++) begin
            for (int a = 0; a < 8; a++) begin
                in_valid = 1'b1; in_data = 8'hB3; in_amt = a[2:0]; in_mode = m[1:0];
                exp_q.push_back(ref_shift(8'hB3, a, m));
                @(posedge clk); #1;
                if (exp_q.size() == 3) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== e) begin
                        errors++;
                        $display("FAIL sweep m=%0d a=%0d got v=%b d=%h want v=1 d=%h", m, a, out_valid, out_data, e);
                    end
                end
            end
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL sweep_drain got v=%b d=%h want v=1 d=%h", out_valid, out_data, e);
            end
        end
        flush();
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] m;
        logic [7:0] e;
    } vec_t;

    task automatic test_vectors();
        vec_t tbl[7];
        tbl[0] = '{d: 8'hB3, a: 3'd3, m: 2'b00, e: 8'h98};
        tbl[1] = '{d: 8'hB3, a: 3'd3, m: 2'b01, e: 8'h16};
        tbl[2] = '{d: 8'hB3, a: 3'd3, m: 2'b10, e: 8'hF6};
`ifdef ROTATE_EN
        tbl[3] = '{d: 8'hB3, a: 3'd3, m: 2'b11, e: 8'h9D};
        tbl[6] = '{d: 8'h81, a: 3'd1, m: 2'b11, e: 8'h03};
`else
        tbl[3] = '{d: 8'hB3, a: 3'd3, m: 2'b11, e: 8'h98};
        tbl[6] = '{d: 8'h81, a: 3'd1, m: 2'b11, e: 8'h02};
`endif
        tbl[4] = '{d: 8'h80, a: 3'd1, m: 2'b00, e: 8'h00};
        tbl[5] = '{d: 8'h80, a: 3'd7, m: 2'b10, e: 8'hFF};
        // one word at a time: exactly 3 edges until the result shows
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = tbl[i].d; in_amt = tbl[i].a; in_mode = tbl[i].m;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_early got v=%b want v=0", i, out_valid); end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== tbl[i].e) begin
                errors++;
                $display("FAIL vec%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, tbl[i].e);
            end
            checks++;
            if (out_zero !== (tbl[i].e == 8'h00)) begin
                errors++;
                $display("FAIL vec%0d_zero got=%b want=%b", i, out_zero, tbl[i].e == 8'h00);
            end
        end
        flush();
    endtask

    task automatic test_backpressure();
        logic [7:0] want[5] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A};
        got.delete();
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1); in_amt = 3'd1; in_mode = 2'b00;
            @(posedge clk); #1;
        end
        // junk offered during the stall must not be accepted
        in_data = 8'hFF; in_amt = 3'd0; out_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h06) begin
                errors++;
                $display("FAIL stall_c%0d got rdy=%b v=%b d=%h want rdy=0 v=1 d=06", c, in_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        checks++;
        if (got.size() != 5) begin errors++; $display("FAIL bp_count got=%0d want=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin errors++; $display("FAIL bp_order%0d got=%h want=%h", i, got[i], want[i]); end
        end
        flush();
    endtask

    task automatic test_bubbles();
        bit pat[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
        bit vq[$];
        bit ev;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = pat[i]; in_data = 8'h0F; in_amt = 3'd2; in_mode = 2'b01;
            vq.push_back(pat[i]);
            @(posedge clk); #1;
            if (vq.size() == 3) begin
                ev = vq.pop_front();
                checks++;
                if (out_valid !== ev || (ev && out_data !== 8'h03)) begin
                    errors++;
                    $display("FAIL bubble_c%0d got v=%b d=%h want v=%b d=03", i, out_valid, out_data, ev);
                end
            end
        end
        flush();
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h11 * (i + 1); in_amt = 3'd0; in_mode = 2'b00;
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL pre_reset got v=%b d=%h want v=1 d=11", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%h z=%b want v=0 d=00 z=0", out_valid, out_data, out_zero);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_c%0d got v=%b want v=0", c, out_valid); end
        end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_sweep();
                test_vectors();
                test_backpressure();
                test_bubbles();
                test_reset_midflight();
            end
            begin
                #200000;
                $display("FAIL timeout got=running want=done");
                errors++;
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
